// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder with byte-lane merging behind valid/ready request and response
// Define DMEM_MISALIGN_EN to perform misaligned accesses, splitting word-crossing ones into two beats.
module dmem_resp #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] st_dat_i,
   input  logic [1:0]            ls_wdth_i,
   input  logic                  ls_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_dat_o,
   output logic                  resp_err_o
);
   localparam int IW = $clog2(MEM_DEPTH);
   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, BASE_ADDR} + LW'(4 * MEM_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, ACC0, ACC1, ERR, RESP} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             st_dat_q;
   logic [1:0]              wdth_q;
   logic                    ls_q;
   logic [31:0]             resp_dat_q, resp_dat_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_err_q;
   logic                    acc, beat1;

   logic [31:0]             mem [MEM_DEPTH];

   // Fault decision on the incoming request; one extra bit catches address wrap.
   logic [2:0]              n_i;
   logic [ADDR_WIDTH:0]     end_addr;
   logic                    fault_i;

   always_comb begin
      case (ls_wdth_i)
         2'b00:   n_i = 3'd1;
         2'b01:   n_i = 3'd2;
         default: n_i = 3'd4;
      endcase
      end_addr = {1'b0, addr_i} + LW'(n_i - 3'd1);
      fault_i  = (ls_wdth_i == 2'b11) || (addr_i < BASE_ADDR) || (end_addr > LAST_ADDR);
`ifndef DMEM_MISALIGN_EN
      if ((ls_wdth_i == 2'b01 && addr_i[0]) || (ls_wdth_i == 2'b10 && addr_i[1:0] != 2'b00))
         fault_i = 1'b1;
`endif
   end

   logic [1:0]              off_q;
   logic [2:0]              n_q;
   logic [ADDR_WIDTH-1:0]   word_off;
   logic [IW-1:0]           idx;

   always_comb begin
      off_q    = addr_q[1:0];
      n_q      = (wdth_q == 2'b00) ? 3'd1 : (wdth_q == 2'b01) ? 3'd2 : 3'd4;
      word_off = addr_q - BASE_ADDR;
      idx      = IW'(word_off >> 2) + (beat1 ? IW'(1) : IW'(0));
   end

   // Map each lane of the current beat to the request byte it carries.
   logic [3:0]              lane_en;
   logic [1:0]              lane_k [4];

   always_comb begin
      int k;
      k       = 0;
      lane_en = '0;
      for (int l = 0; l < 4; l++) begin
         lane_k[l] = 2'd0;
         k = l + (beat1 ? 4 : 0) - int'(off_q);
         if (k >= 0 && k < int'(n_q)) begin
            lane_en[l] = 1'b1;
            lane_k[l]  = 2'(k);
         end
      end
   end

   logic [31:0]             rd_word, wr_word;

   always_comb begin
      rd_word    = mem[idx];
      wr_word    = rd_word;
      resp_dat_d = resp_dat_q;
      for (int l = 0; l < 4; l++) begin
         if (lane_en[l]) begin
            wr_word[8*l +: 8]              = st_dat_q[8*lane_k[l] +: 8];
            resp_dat_d[8*lane_k[l] +: 8]   = rd_word[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc && ls_q)
         mem[idx] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      case (state_q)
         IDLE: if (req_valid_i) state_d = fault_i ? ERR : ACC0;
`ifdef DMEM_MISALIGN_EN
         ACC0: state_d = ({1'b0, off_q} + n_q > 3'd4) ? ACC1 : RESP;
`else
         ACC0: state_d = RESP;
`endif
         ACC1: state_d = RESP;
         ERR:  state_d = RESP;
         RESP: begin
            resp_valid_d = !(resp_valid_q && resp_ready_i);
            if (resp_valid_q && resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == IDLE);
      acc         = (state_q == ACC0) || (state_q == ACC1);
      beat1       = (state_q == ACC1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         st_dat_q     <= '0;
         wdth_q       <= 2'b00;
         ls_q         <= 1'b0;
         resp_dat_q   <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid_i) begin
            addr_q     <= addr_i;
            st_dat_q   <= st_dat_i;
            wdth_q     <= ls_wdth_i;
            ls_q       <= ls_i;
            resp_dat_q <= '0;
            resp_err_q <= fault_i;
         end else if (acc && !ls_q) begin
            resp_dat_q <= resp_dat_d;
         end
         resp_valid_q <= resp_valid_d;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_dat_o   = resp_dat_q;
   assign resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed self-checking bench for dmem_resp
// Expectations follow DMEM_MISALIGN_EN when it is defined.
module tb_dmem_resp;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] addr_i;
   logic [31:0] st_dat_i;
   logic [1:0]  ls_wdth_i;
   logic        ls_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_dat_o;
   logic        resp_err_o;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_resp dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .addr_i       (addr_i),
      .st_dat_i     (st_dat_i),
      .ls_wdth_i    (ls_wdth_i),
      .ls_i         (ls_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_dat_o   (resp_dat_o),
      .resp_err_o   (resp_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w, input logic st);
      @(negedge clk);
      addr_i      = a;
      st_dat_i    = d;
      ls_wdth_i   = w;
      ls_i        = st;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid_o && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] w, input logic st,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
      int lat;
      send(a, d, w, st);
      wait_resp(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_dat"}, resp_dat_o, exp_d);
      chk({tag, "_err"}, {31'd0, resp_err_o}, {31'd0, exp_e});
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1 resp_ready_i = 1'b0;
      chk({tag, "_vld_clr"}, {31'd0, resp_valid_o}, 32'd0);
   endtask

   initial begin
      int lat;
      rst_n        = 1'b0;
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b0;
      addr_i       = '0;
      st_dat_i     = '0;
      ls_wdth_i    = 2'b00;
      ls_i         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
      chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
      chk("rst_dat", resp_dat_o, 32'd0);
      chk("rst_err", {31'd0, resp_err_o}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      access("sw10",  32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h0, 1'b0, 2);
      access("lw10",  32'h8000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
      access("sb13",  32'h8000_0013, 32'h0000_00A5, 2'b00, 1'b1, 32'h0, 1'b0, 2);
      access("lw10b", 32'h8000_0010, 32'h0,         2'b10, 1'b0, 32'hA5AD_BEEF, 1'b0, 2);
      access("lb13",  32'h8000_0013, 32'h0,         2'b00, 1'b0, 32'h0000_00A5, 1'b0, 2);
      access("lh12",  32'h8000_0012, 32'h0,         2'b01, 1'b0, 32'h0000_A5AD, 1'b0, 2);

      access("sw00",  32'h8000_0000, 32'h1122_3344, 2'b10, 1'b1, 32'h0, 1'b0, 2);
      access("sw04",  32'h8000_0004, 32'h5566_7788, 2'b10, 1'b1, 32'h0, 1'b0, 2);
`ifdef DMEM_MISALIGN_EN
      access("sh03",  32'h8000_0003, 32'h0000_1234, 2'b01, 1'b1, 32'h0, 1'b0, 3);
      access("lb03",  32'h8000_0003, 32'h0,         2'b00, 1'b0, 32'h0000_0034, 1'b0, 2);
      access("lb04",  32'h8000_0004, 32'h0,         2'b00, 1'b0, 32'h0000_0012, 1'b0, 2);
      access("lh03",  32'h8000_0003, 32'h0,         2'b01, 1'b0, 32'h0000_1234, 1'b0, 3);
      access("lw00m", 32'h8000_0000, 32'h0,         2'b10, 1'b0, 32'h3422_3344, 1'b0, 2);
      access("lw04m", 32'h8000_0004, 32'h0,         2'b10, 1'b0, 32'h5566_7712, 1'b0, 2);
`else
      access("sh03",  32'h8000_0003, 32'h0000_1234, 2'b01, 1'b1, 32'h0, 1'b1, 2);
      access("lw01",  32'h8000_0001, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 2);
      access("lw00u", 32'h8000_0000, 32'h0,         2'b10, 1'b0, 32'h1122_3344, 1'b0, 2);
      access("lw04u", 32'h8000_0004, 32'h0,         2'b10, 1'b0, 32'h5566_7788, 1'b0, 2);
`endif

      access("lw_low",  32'h7FFF_FFFC, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 2);
      access("lw_high", 32'h8000_1000, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 2);
      access("sw_high", 32'h8000_1000, 32'h0BAD_0BAD, 2'b10, 1'b1, 32'h0, 1'b1, 2);
      access("lh_wrap", 32'hFFFF_FFFF, 32'h0,         2'b01, 1'b0, 32'h0, 1'b1, 2);
      access("lw_w11",  32'h8000_0010, 32'h0,         2'b11, 1'b0, 32'h0, 1'b1, 2);
      access("sw_w11",  32'h8000_0010, 32'hFFFF_FFFF, 2'b11, 1'b1, 32'h0, 1'b1, 2);
      access("lw10c",   32'h8000_0010, 32'h0,         2'b10, 1'b0, 32'hA5AD_BEEF, 1'b0, 2);
      access("sw_last", 32'h8000_0FFC, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h0, 1'b0, 2);
      access("lw_last", 32'h8000_0FFC, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2);
      access("lb_last", 32'h8000_0FFF, 32'h0,         2'b00, 1'b0, 32'h0000_00CA, 1'b0, 2);

      // Response held off by the LSU: outputs must stay frozen.
      send(32'h8000_0010, 32'h0, 2'b10, 1'b0);
      wait_resp(lat);
      chk("hold_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold_vld%0d", i), {31'd0, resp_valid_o}, 32'd1);
         chk($sformatf("hold_dat%0d", i), resp_dat_o, 32'hA5AD_BEEF);
         chk($sformatf("hold_rdy%0d", i), {31'd0, req_ready_o}, 32'd0);
      end
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1 resp_ready_i = 1'b0;
      chk("hold_done", {31'd0, req_ready_o}, 32'd1);

      // Reset while the access beat is in flight.
      send(32'h8000_0004, 32'h0, 2'b01, 1'b0);
      chk("acc0_rdy", {31'd0, req_ready_o}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_acc0_rdy", {31'd0, req_ready_o}, 32'd1);
      chk("rst_acc0_vld", {31'd0, resp_valid_o}, 32'd0);
      chk("rst_acc0_dat", resp_dat_o, 32'd0);
      chk("rst_acc0_err", {31'd0, resp_err_o}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Reset while a load response is pending.
      send(32'h8000_0010, 32'h0, 2'b10, 1'b0);
      wait_resp(lat);
      chk("pend_dat", resp_dat_o, 32'hA5AD_BEEF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_resp_vld", {31'd0, resp_valid_o}, 32'd0);
      chk("rst_resp_dat", resp_dat_o, 32'd0);
      chk("rst_resp_rdy", {31'd0, req_ready_o}, 32'd1);
      @(negedge clk) rst_n = 1'b1;

      // Faulting response pending, then reset clears the error flag.
      send(32'h7FFF_FFFC, 32'h0, 2'b10, 1'b0);
      wait_resp(lat);
      chk("pend_err", {31'd0, resp_err_o}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_err_clr", {31'd0, resp_err_o}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      access("lw_after", 32'h8000_0010, 32'h0, 2'b10, 1'b0, 32'hA5AD_BEEF, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
